// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud divider helper used by both receive and transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  // Clocks per sample tick; the result must be at least 2.
  function automatic int calc_tick_div(input int clk_freq, input int baud,
                                       input int os = OVERSAMPLE);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running sample-tick divider: pulses tick_o on the terminal count and
// restarts from zero whenever clear_i is asserted.
module uart_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: 16x oversampled, 3-sample majority vote per bit, framing
// error detection with a break-recovery state so a stuck-low line stays quiet.
module uart_rx_frame #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       rxdDataReady,
  output logic       frameError,
  output logic       rxdBusy
);

  import uart_pkg::*;

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam logic [3:0] TIDX_LAST = 4'(OVERSAMPLE - 1);

  rx_state_e      state_q, state_d;
  logic [1:0]     sync_q;
  logic [3:0]     tidx_q, tidx_d;
  logic [2:0]     bidx_q, bidx_d;
  logic [1:0]     samp_q, samp_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     data_q, data_d;
  logic           ready_q, ready_d;
  logic           ferr_q, ferr_d;
  logic           rs, tick, tick_clr, maj, mid, wrap;

  uart_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (tick_clr),
    .tick_o  (tick)
  );

  assign rs   = sync_q[1];
  // Third vote is the live sample taken at the deciding tick.
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rs) | (samp_q[1] & rs);
  assign mid  = tick && (tidx_q == 4'(SAMPLE_HI));
  assign wrap = tick && (tidx_q == TIDX_LAST);

  always_comb begin
    state_d  = state_q;
    tidx_d   = tidx_q;
    bidx_d   = bidx_q;
    samp_d   = samp_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    ferr_d   = 1'b0;
    tick_clr = 1'b0;

    if (tick && state_q != ST_IDLE) begin
      tidx_d = tidx_q + 4'd1;
      if (tidx_q == 4'(SAMPLE_LO))     samp_d[0] = rs;
      if (tidx_q == 4'(SAMPLE_LO + 1)) samp_d[1] = rs;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rs) begin
          state_d  = ST_START;
          tidx_d   = '0;
          tick_clr = 1'b1;
        end
      end
      ST_START: begin
        if (mid && maj) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d = ST_DATA;
          bidx_d  = '0;
        end
      end
      ST_DATA: begin
        if (mid) shreg_d[bidx_q] = maj;
        if (wrap) begin
          if (bidx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
          else                             bidx_d  = bidx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (mid) begin
          if (maj) begin
            data_d  = shreg_q;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
            tidx_d  = '0;
          end
        end
      end
      ST_BREAK: begin
        // tidx counts consecutive high ticks; any low cycle restarts it.
        if (!rs)       tidx_d  = '0;
        else if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      tidx_q  <= '0;
      bidx_q  <= '0;
      samp_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      tidx_q  <= tidx_d;
      bidx_q  <= bidx_d;
      samp_q  <= samp_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data         = data_q;
  assign rxdDataReady = ready_q;
  assign frameError   = ferr_q;
  assign rxdBusy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at 160 clocks per bit: vector table,
// hand-written corner sequences and randomized frames against a byte-level model.
module tb_uart_rx_frame;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       rxdDataReady, frameError, rxdBusy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int ferr_cnt = 0;
  int last_start = 0;
  int strobe_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic prev_ready = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0;

  uart_rx_frame #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .data         (data),
    .rxdDataReady (rxdDataReady),
    .frameError   (frameError),
    .rxdBusy      (rxdBusy)
  );

  // Clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard / pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rxdDataReady) begin
      ready_cnt++;
      strobe_cyc.push_back(cyc);
      check("ready_excl", {31'd0, frameError}, 32'd0);
      check("ready_width", {31'd0, prev_ready}, 32'd0);
      check("busy_fall", {30'd0, prev_busy, rxdBusy}, 32'd2);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got data %0h expected no strobe", data);
      end else begin
        check("sb_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (frameError) begin
      ferr_cnt++;
      check("ferr_width", {31'd0, prev_ferr}, 32'd0);
    end
    prev_ready = rxdDataReady;
    prev_ferr  = frameError;
    prev_busy  = rxdBusy;
  end

  // Drivers
  task automatic line(input int n, input logic lvl);
    repeat (n) begin
      @(negedge clk);
      rxd = lvl;
    end
  endtask

  // gl_len > 0 inverts data bit 3 for gl_len clocks around its middle.
  task automatic send_frame(input logic [7:0] b, input int per, input logic stop, input int gl_len);
    logic lvl;
    for (int i = 0; i < 10; i++) begin
      lvl = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) last_start = cyc;
        if (gl_len > 0 && i == 4 && c >= per/2 - 2 && c < per/2 - 2 + gl_len) rxd = ~lvl;
        else rxd = lvl;
      end
    end
  endtask

  typedef struct {
    logic [7:0] b;
    int         per;
    logic       stop;
    int         gl_len;
    int         exp_ready;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int r0, f0, d;

  initial begin
    vecs[0] = '{8'h35, 160, 1'b1, 0, 1, 0};
    vecs[1] = '{8'h5A, 165, 1'b1, 5, 1, 0};
    vecs[2] = '{8'h5A, 155, 1'b1, 5, 1, 0};
    vecs[3] = '{8'h00, 160, 1'b1, 0, 1, 0};
    vecs[4] = '{8'hFF, 158, 1'b1, 0, 1, 0};
    vecs[5] = '{8'h39, 162, 1'b1, 0, 1, 0};

    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    line(5, 1'b1);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_ready", {31'd0, rxdDataReady}, 32'd0);
    check("rst_ferr", {31'd0, frameError}, 32'd0);
    check("rst_busy", {31'd0, rxdBusy}, 32'd0);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      r0 = ready_cnt;
      f0 = ferr_cnt;
      if (vecs[v].exp_ready != 0) begin
        exp_q.push_back(vecs[v].b);
        last_good = vecs[v].b;
      end
      send_frame(vecs[v].b, vecs[v].per, vecs[v].stop, vecs[v].gl_len);
      if (v == 0) begin
        d = strobe_cyc.size() > 0 ? strobe_cyc[$] - last_start : -1;
        check("latency_ok", {31'd0, (d >= 1538 && d <= 1548)}, 32'd1);
      end
      line(200, 1'b1);
      check($sformatf("vec%0d_ready", v), ready_cnt - r0, vecs[v].exp_ready);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_data", v), {24'd0, data}, {24'd0, last_good});
      check($sformatf("vec%0d_idle", v), {31'd0, rxdBusy}, 32'd0);
    end

    // Back-to-back frames without idle gap
    r0 = ready_cnt;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h39);
    send_frame(8'h31, BIT, 1'b1, 0);
    send_frame(8'h39, BIT, 1'b1, 0);
    line(200, 1'b1);
    last_good = 8'h39;
    check("b2b_count", ready_cnt - r0, 32'd2);
    d = strobe_cyc.size() >= 2 ? strobe_cyc[$] - strobe_cyc[$-1] : -1;
    check("b2b_spacing", {31'd0, (d >= 1598 && d <= 1602)}, 32'd1);
    check("b2b_data", {24'd0, data}, 32'h39);

    // 40-clock glitch on idle line
    r0 = ready_cnt;
    f0 = ferr_cnt;
    line(20, 1'b0);
    check("glitch_busy", {31'd0, rxdBusy}, 32'd1);
    line(20, 1'b0);
    line(300, 1'b1);
    check("glitch_ready", ready_cnt - r0, 32'd0);
    check("glitch_ferr", ferr_cnt - f0, 32'd0);
    check("glitch_idle", {31'd0, rxdBusy}, 32'd0);
    check("glitch_data", {24'd0, data}, {24'd0, last_good});

    // Framing error followed by a long break
    r0 = ready_cnt;
    f0 = ferr_cnt;
    send_frame(8'h42, BIT, 1'b0, 0);
    line(3000, 1'b0);
    check("brk_ferr", ferr_cnt - f0, 32'd1);
    check("brk_ready", ready_cnt - r0, 32'd0);
    check("brk_data", {24'd0, data}, {24'd0, last_good});
    line(100, 1'b1);
    check("brk_hold", {31'd0, rxdBusy}, 32'd1);
    line(150, 1'b1);
    check("brk_exit", {31'd0, rxdBusy}, 32'd0);
    check("brk_ferr_after", ferr_cnt - f0, 32'd1);

    // Reset while idle
    reset = 1'b1;
    line(3, 1'b1);
    reset = 1'b0;
    line(2, 1'b1);
    last_good = 8'h00;
    check("idle_rst_data", {24'd0, data}, 32'd0);
    check("idle_rst_busy", {31'd0, rxdBusy}, 32'd0);

    // Reset halfway through a frame, then a clean frame
    exp_q.push_back(8'h77);
    last_good = 8'h77;
    send_frame(8'h77, BIT, 1'b1, 0);
    line(100, 1'b1);
    r0 = ready_cnt;
    fork
      send_frame(8'hF0, BIT, 1'b1, 0);
      begin
        repeat (800) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    line(300, 1'b1);
    last_good = 8'h00;
    check("midrst_ready", ready_cnt - r0, 32'd0);
    check("midrst_data", {24'd0, data}, 32'd0);
    check("midrst_busy", {31'd0, rxdBusy}, 32'd0);
    exp_q.push_back(8'h33);
    last_good = 8'h33;
    send_frame(8'h33, BIT, 1'b1, 0);
    line(200, 1'b1);
    check("post_rst_data", {24'd0, data}, 32'h33);

    // Randomized frames: model predicts each byte with a good stop bit
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      last_good = b;
      send_frame(b, $urandom_range(155, 165), 1'b1, ($urandom_range(0, 1) != 0) ? 5 : 0);
      line($urandom_range(0, 200), 1'b1);
    end
    line(300, 1'b1);
    check("rand_last_data", {24'd0, data}, {24'd0, last_good});
    check("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #5ms;
    $display("FAIL timeout: cycle %0d reached without completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
